psx_poll_master: RTL
====================

# psx_poll_master

Console-side master that runs one complete PSX digital-pad poll transaction on request. Drives attention, the serial clock and the command line; samples the pad's data line; waits for the pad's acknowledge pulse between bytes. Delivers the two button bytes and the ID byte to the rest of the design. Sits between game/logic blocks and the external pad (or the FPGA pad model) on the shared `clk` domain.

## Interface
- `CLK_DIV`, 100: `clk` cycles per `psx_clk` half-period. Minimum 2.
- `ATT_SETUP`, 100: `clk` cycles from `psx_att` falling to the first `psx_clk` falling edge.
- `ACK_TIMEOUT`, 1000: maximum `clk` cycles to wait for `psx_ack` low after a byte.
- `clk` in 1: system clock; every register is clocked on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request one poll; honoured only in IDLE.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done` out 1: one-cycle pulse at the end of every poll, successful or failed.
- `error` out 1: status of the last poll; 1 means ack timeout or bad ID/marker.
- `buttons` out 16: {data byte 2, data byte 1}; raw active-low pad bits.
- `pad_id` out 8: second received byte (0x41 for a digital pad).
- `psx_att` out 1: attention, active-low.
- `psx_clk` out 1: serial clock, idles high.
- `psx_cmd` out 1: command bit, LSB first.
- `psx_data` in 1: pad data, asynchronous.
- `psx_ack` in 1: pad acknowledge, active-low, asynchronous.

## Operation
- Reset values: `psx_att`=1, `psx_clk`=1, `psx_cmd`=1, `busy`=0, `done`=0, `error`=0, `buttons`=16'hFFFF, `pad_id`=8'hFF. State IDLE.
- `psx_data` and `psx_ack` pass through 2-flop synchronizers before any use.
- TX bytes by index 0..4: 0x01, 0x42, 0x00, 0x00, 0x00. RX bytes: index 0 is ignored, 1 goes to ID, 2 is the marker, 3 is data1, 4 is data2.
- States:
  - IDLE: on `start`, go to SETUP with `psx_att`=0, `busy`=1, byte=0, bit=0.
  - SETUP: wait ATT_SETUP cycles, then go to LOW.
  - LOW: `psx_clk`=0; `psx_cmd`=tx[byte][bit], set on entry; hold CLK_DIV cycles, then go to HIGH.
  - HIGH: `psx_clk`=1; hold CLK_DIV cycles. On the last cycle, shift the synced data into the rx shift register (LSB first). After bit 7, go to ACK if byte<4, else go to FINISH. Otherwise go to LOW with bit+1.
  - ACK: `psx_cmd`=1. On the first cycle the synced ack reads 0, store the byte, then byte+1, bit=0, and go to LOW. If ACK_TIMEOUT cycles elapse with no ack, set the fail flag and go to FINISH.
  - FINISH: `psx_att`=1, `psx_clk`=1, `psx_cmd`=1, `done`=1, `busy`=0, then go to IDLE.
    - Success means no timeout, ID byte = 0x41 and marker = 0x5A.
    - On success: load `buttons` and `pad_id`, and clear `error`.
    - Otherwise: set `error`; `buttons` and `pad_id` hold their previous values.
- A `start` asserted while `busy` is ignored, not queued. A `start` in the same cycle as `done` is also ignored.
- `rst` mid-transaction forces all reset values on the next edge, including `psx_att`=1.
- Counters:
  - Use a single down-counter sized for max(CLK_DIV, ATT_SETUP, ACK_TIMEOUT).
  - Bit index is 3 bits and byte index is 3 bits. Neither wraps within a poll.

## Timing
- Accepted `start` at edge N gives `psx_att` low at N+1. The first `psx_clk` fall is at N+1+ATT_SETUP.
- Bit period is 2·CLK_DIV cycles. The sample point is 2 cycles of synchronizer latency behind the real `psx_clk` rise plus CLK_DIV−1 cycles.
- Ack detection latency is 2 cycles after the pin falls.
- Successful poll duration: ATT_SETUP + 40·2·CLK_DIV + Σ ack waits + 2 cycles, from `start` to `done`.
- `buttons`, `pad_id` and `error` update in the same cycle `done`=1.

## Structure
- Package `psx_pkg` holds:
  - state enum;
  - `PSX_CMD_START`=8'h01, `PSX_CMD_POLL`=8'h42, `PSX_ID_DIGITAL`=8'h41, `PSX_MARKER`=8'h5A;
  - `PSX_NUM_BYTES`=5.
- Sub-module `psx_sync2` is a 2-flop synchronizer, with reset value 1. It is instantiated twice, once for data and once for ack.

## Test plan
- Pad model returns data1=0xFE, data2=0xFD and acks after bytes 0–3. One `start` gives `done` with `error`=0, `buttons`=16'hFDFE, `pad_id`=8'h41, and `psx_cmd` bytes observed as 01 42 00 00 00.
- Pad never acks. `done` pulses ACK_TIMEOUT+2 cycles after byte 0 ends; `error`=1, `buttons` stays 16'hFFFF and `psx_att` returns to 1.
- Pad returns marker 0x00 instead of 0x5A. `error`=1 and `buttons` is unchanged from the prior successful poll.
- A second `start` pulsed while `busy` gives exactly one `done`. A later `start` with pad data 0x7F/0xFF gives `buttons`=16'hFF7F and clears `error`.
- `rst` asserted mid-byte 2. The next cycle shows `psx_att`=1, `psx_clk`=1, `busy`=0, `buttons`=16'hFFFF, and a subsequent poll succeeds.
- With CLK_DIV=2, `psx_clk` high and low phases are each exactly 2 cycles, and `psx_cmd` is stable for the whole high phase.

Source files
------------

// File: rtl/psx_pkg.sv
// Shared types and constants for the PSX digital-pad poll master.
package psx_pkg;

  // Poll sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_ACK    = 3'd4,
    ST_FINISH = 3'd5
  } psx_state_e;

  localparam logic [7:0] PSX_CMD_START  = 8'h01;
  localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
  localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
  localparam logic [7:0] PSX_MARKER     = 8'h5A;

  localparam int PSX_NUM_BYTES = 5;

  // Index of the final byte of a poll; no ack is expected after it.
  localparam logic [2:0] PSX_LAST_BYTE = 3'(PSX_NUM_BYTES - 1);
  localparam logic [2:0] PSX_LAST_BIT  = 3'd7;

  // Byte sent on the command line for a given byte index.
  function automatic logic [7:0] psx_tx_byte(input logic [2:0] byte_idx);
    logic [7:0] tx_byte;
    case (byte_idx)
      3'd0:    tx_byte = PSX_CMD_START;
      3'd1:    tx_byte = PSX_CMD_POLL;
      default: tx_byte = 8'h00;
    endcase
    return tx_byte;
  endfunction

  // Single command bit, LSB first within each byte.
  function automatic logic psx_tx_bit(input logic [2:0] byte_idx,
                                      input logic [2:0] bit_idx);
    logic [7:0] tx_byte;
    tx_byte = psx_tx_byte(byte_idx);
    return tx_byte[bit_idx];
  endfunction

  // Largest of three timing parameters, used to size the shared counter.
  function automatic int psx_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/psx_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs; idles at 1.
module psx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta_r;
  logic sync_r;

  // Double-register the pin into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  assign dout = sync_r;

endmodule

// File: rtl/psx_poll_master.sv
// Console-side master: runs one PSX digital-pad poll per accepted start.
module psx_poll_master
  import psx_pkg::*;
#(
  parameter int CLK_DIV     = 100,
  parameter int ATT_SETUP   = 100,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] buttons,
  output logic [7:0]  pad_id,
  output logic        psx_att,
  output logic        psx_clk,
  output logic        psx_cmd,
  input  logic        psx_data,
  input  logic        psx_ack
);

  localparam int CNT_MAX = psx_max3(CLK_DIV, ATT_SETUP, ACK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Phase counters run from LOAD down to zero inclusive. The ack wait is
  // loaded with the full timeout so the give-up decision is taken only
  // after ACK_TIMEOUT whole cycles have passed without an ack.
  localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(ATT_SETUP - 1);
  localparam logic [CNT_W-1:0] ACK_LOAD   = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  psx_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_r;
  logic [2:0]       byte_r;
  logic [7:0]       rx_shift_r;
  logic [7:0]       id_r;
  logic [7:0]       marker_r;
  logic [7:0]       data1_r;
  logic             fail_r;

  logic             data_sync_s;
  logic             ack_sync_s;
  logic             poll_ok_s;

  psx_sync2 u_sync_data (
    .clk  (clk),
    .rst  (rst),
    .din  (psx_data),
    .dout (data_sync_s)
  );

  psx_sync2 u_sync_ack (
    .clk  (clk),
    .rst  (rst),
    .din  (psx_ack),
    .dout (ack_sync_s)
  );

  // Poll verdict: every ack arrived and the pad identified as a digital pad
  always_comb begin
    poll_ok_s = 1'b0;
    if (!fail_r && (id_r == PSX_ID_DIGITAL) && (marker_r == PSX_MARKER)) begin
      poll_ok_s = 1'b1;
    end else begin
      poll_ok_s = 1'b0;
    end
  end

  // Poll sequencer with registered pad-side and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      bit_r      <= 3'd0;
      byte_r     <= 3'd0;
      rx_shift_r <= 8'hFF;
      id_r       <= 8'hFF;
      marker_r   <= 8'hFF;
      data1_r    <= 8'hFF;
      fail_r     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      buttons    <= 16'hFFFF;
      pad_id     <= 8'hFF;
      psx_att    <= 1'b1;
      psx_clk    <= 1'b1;
      psx_cmd    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A start coinciding with the done pulse belongs to the old poll
          if (start && !done) begin
            state_r <= ST_SETUP;
            psx_att <= 1'b0;
            busy    <= 1'b1;
            byte_r  <= 3'd0;
            bit_r   <= 3'd0;
            fail_r  <= 1'b0;
            cnt_r   <= SETUP_LOAD;
          end
        end

        ST_SETUP: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= ST_LOW;
            psx_clk <= 1'b0;
            psx_cmd <= psx_tx_bit(byte_r, bit_r);
            cnt_r   <= DIV_LOAD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        ST_LOW: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= ST_HIGH;
            psx_clk <= 1'b1;
            cnt_r   <= DIV_LOAD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        ST_HIGH: begin
          if (cnt_r == CNT_ZERO) begin
            // Sample as late as possible so the synchronizer has settled
            rx_shift_r <= {data_sync_s, rx_shift_r[7:1]};
            if (bit_r == PSX_LAST_BIT) begin
              if (byte_r == PSX_LAST_BYTE) begin
                state_r <= ST_FINISH;
              end else begin
                state_r <= ST_ACK;
                psx_cmd <= 1'b1;
                cnt_r   <= ACK_LOAD;
              end
            end else begin
              state_r <= ST_LOW;
              bit_r   <= bit_r + 3'd1;
              psx_clk <= 1'b0;
              psx_cmd <= psx_tx_bit(byte_r, bit_r + 3'd1);
              cnt_r   <= DIV_LOAD;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        ST_ACK: begin
          if (!ack_sync_s) begin
            case (byte_r)
              3'd1:    id_r     <= rx_shift_r;
              3'd2:    marker_r <= rx_shift_r;
              3'd3:    data1_r  <= rx_shift_r;
              default: id_r     <= id_r;
            endcase
            byte_r  <= byte_r + 3'd1;
            bit_r   <= 3'd0;
            state_r <= ST_LOW;
            psx_clk <= 1'b0;
            psx_cmd <= psx_tx_bit(byte_r + 3'd1, 3'd0);
            cnt_r   <= DIV_LOAD;
          end else if (cnt_r == CNT_ZERO) begin
            fail_r  <= 1'b1;
            state_r <= ST_FINISH;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        ST_FINISH: begin
          psx_att <= 1'b1;
          psx_clk <= 1'b1;
          psx_cmd <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
          // The final byte is still in the shift register at this point
          if (poll_ok_s) begin
            buttons <= {rx_shift_r, data1_r};
            pad_id  <= id_r;
            error   <= 1'b0;
          end else begin
            error <= 1'b1;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          psx_att <= 1'b1;
          psx_clk <= 1'b1;
          psx_cmd <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
